// File: rtl/awg_loader.sv
`timescale 1ns/1ps
// awg_loader
// Upstream sequencer for the arbitrary-waveform playback memory.
// It unpacks 32-bit sample-pair words from a valid/ready stream into the
// memory write port, then sequences playback with a programmable length
// and repeat count.
//
// Ports
//   wclk, rst                         clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready sample-pair stream ([13:0]=n, [29:16]=n+1)
//   cfg_len                           waveform length in samples (latched on load_start)
//   cfg_reps                          repeat count, 0 = infinite (latched on trigger)
//   load_start, trigger, stop         single-cycle command pulses
//   we, waddr, data_in                playback memory write port
//   re, arb_rst_n                     playback read enable / read-pointer reset (active low)
//   loaded, playing, err_short        status
module awg_loader #(
    parameter int DAC_DATA_WIDTH = 14,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic                      wclk,
    input  logic                      rst,
    input  logic [31:0]               s_tdata,
    input  logic                      s_tvalid,
    input  logic                      s_tlast,
    output logic                      s_tready,
    input  logic [ADDR_WIDTH:0]       cfg_len,
    input  logic [15:0]               cfg_reps,
    input  logic                      load_start,
    input  logic                      trigger,
    input  logic                      stop,
    output logic                      we,
    output logic [ADDR_WIDTH-1:0]     waddr,
    output logic [DAC_DATA_WIDTH-1:0] data_in,
    output logic                      re,
    output logic                      arb_rst_n,
    output logic                      loaded,
    output logic                      playing,
    output logic                      err_short
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_LO, S_LOAD_HI, S_LOADED, S_PREP, S_PLAY, S_GAP
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                      r_state;
    state_t                      w_state_next;

    logic [ADDR_WIDTH:0]         r_len, w_len_next;
    logic [ADDR_WIDTH:0]         r_wptr, w_wptr_next;
    logic [ADDR_WIDTH:0]         r_rcnt, w_rcnt_next;
    logic [DAC_DATA_WIDTH-1:0]   r_hold, w_hold_next;
    logic                        r_last, w_last_next;
    logic                        r_err, w_err_next;
    logic [15:0]                 r_reps, w_reps_next;
    logic [15:0]                 r_rep, w_rep_next;
    logic                        r_we, w_we_next;
    logic [ADDR_WIDTH-1:0]       r_waddr, w_waddr_next;
    logic [DAC_DATA_WIDTH-1:0]   r_data, w_data_next;
    logic                        r_tready, r_re, r_arb_rst_n, r_loaded, r_playing;

    logic [ADDR_WIDTH:0]         w_wptr_inc;
    logic [15:0]                 w_rep_inc;
    logic                        w_unused;

    assign w_wptr_inc = r_wptr + 1'b1;
    assign w_rep_inc  = r_rep + 16'd1;
    // The spare bits of each half-word carry nothing.
    assign w_unused   = ^{s_tdata[31:30], s_tdata[15:14]};

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_wptr_next  = r_wptr;
        w_rcnt_next  = r_rcnt;
        w_hold_next  = r_hold;
        w_last_next  = r_last;
        w_err_next   = r_err;
        w_reps_next  = r_reps;
        w_rep_next   = r_rep;
        w_we_next    = 1'b0;
        w_waddr_next = r_waddr;
        w_data_next  = r_data;

        case (r_state)
            S_IDLE, S_LOADED: begin
                // A new load takes priority over a trigger arriving together.
                if (load_start && (cfg_len != '0)) begin
                    w_len_next   = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
                    w_err_next   = 1'b0;
                    w_wptr_next  = '0;
                    w_last_next  = 1'b0;
                    w_state_next = S_LOAD_LO;
                end else if ((r_state == S_LOADED) && trigger) begin
                    w_reps_next  = cfg_reps;
                    w_rep_next   = '0;
                    w_state_next = S_PREP;
                end
            end
            S_LOAD_LO: begin
                if (s_tvalid) begin
                    w_we_next    = 1'b1;
                    w_waddr_next = r_wptr[ADDR_WIDTH-1:0];
                    w_data_next  = s_tdata[DAC_DATA_WIDTH-1:0];
                    w_hold_next  = s_tdata[16 +: DAC_DATA_WIDTH];
                    w_last_next  = s_tlast;
                    w_wptr_next  = w_wptr_inc;
                    // Odd lengths end here and the high half is dropped.
                    w_state_next = (w_wptr_inc == r_len) ? S_LOADED : S_LOAD_HI;
                end
            end
            S_LOAD_HI: begin
                w_we_next    = 1'b1;
                w_waddr_next = r_wptr[ADDR_WIDTH-1:0];
                w_data_next  = r_hold;
                w_wptr_next  = w_wptr_inc;
                if (w_wptr_inc == r_len) begin
                    w_state_next = S_LOADED;
                end else if (r_last) begin
                    // Transfer ended early: shrink the waveform to what arrived.
                    w_err_next   = 1'b1;
                    w_len_next   = w_wptr_inc;
                    w_state_next = S_LOADED;
                end else begin
                    w_state_next = S_LOAD_LO;
                end
            end
            S_PREP: begin
                w_rcnt_next  = '0;
                w_state_next = S_PLAY;
            end
            S_PLAY: begin
                if (r_rcnt == r_len - 1'b1) begin
                    w_rep_next = w_rep_inc;
                    // cfg_reps == 0 never terminates: the explicit zero test
                    // keeps a wrapped rep from matching.
                    if ((r_reps != '0) && (w_rep_inc == r_reps)) begin
                        w_state_next = S_LOADED;
                    end else begin
                        w_state_next = S_GAP;
                    end
                end else begin
                    w_rcnt_next = r_rcnt + 1'b1;
                end
            end
            S_GAP: begin
                w_rcnt_next  = '0;
                w_state_next = S_PLAY;
            end
            default: w_state_next = S_IDLE;
        endcase

        if (stop && (r_state inside {S_PREP, S_PLAY, S_GAP})) begin
            w_state_next = S_LOADED;
        end
    end

    // Status and playback controls are decoded from the next state so every
    // output comes straight from a flop and changes on the same edge as state.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_wptr      <= '0;
            r_rcnt      <= '0;
            r_hold      <= '0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
            r_reps      <= '0;
            r_rep       <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_data      <= '0;
            r_tready    <= 1'b0;
            r_re        <= 1'b0;
            r_arb_rst_n <= 1'b0;
            r_loaded    <= 1'b0;
            r_playing   <= 1'b0;
        end else begin
            r_len       <= w_len_next;
            r_wptr      <= w_wptr_next;
            r_rcnt      <= w_rcnt_next;
            r_hold      <= w_hold_next;
            r_last      <= w_last_next;
            r_err       <= w_err_next;
            r_reps      <= w_reps_next;
            r_rep       <= w_rep_next;
            r_we        <= w_we_next;
            r_waddr     <= w_waddr_next;
            r_data      <= w_data_next;
            r_tready    <= (w_state_next == S_LOAD_LO);
            r_re        <= (w_state_next == S_PLAY);
            r_arb_rst_n <= !(w_state_next inside {S_PREP, S_GAP});
            r_loaded    <= (w_state_next inside {S_LOADED, S_PREP, S_PLAY, S_GAP});
            r_playing   <= (w_state_next inside {S_PREP, S_PLAY, S_GAP});
        end
    end

    assign s_tready  = r_tready;
    assign we        = r_we;
    assign waddr     = r_waddr;
    assign data_in   = r_data;
    assign re        = r_re;
    assign arb_rst_n = r_arb_rst_n;
    assign loaded    = r_loaded;
    assign playing   = r_playing;
    assign err_short = r_err;

endmodule

// File: tb/tb_awg_loader.sv
`timescale 1ns/1ps
// Testbench for awg_loader: table of load/playback cases checked against a
// sample-list / playback-trace reference model, plus hand-written sequences
// for stop, simultaneous events and reset during a load.
module tb_awg_loader;

    logic        wclk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [16:0] cfg_len;
    logic [15:0] cfg_reps;
    logic        load_start, trigger, stop;
    logic        we;
    logic [15:0] waddr;
    logic [13:0] data_in;
    logic        re, arb_rst_n, loaded, playing, err_short;

    awg_loader #(.DAC_DATA_WIDTH(14), .ADDR_WIDTH(16)) dut (
        .wclk(wclk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .cfg_len(cfg_len), .cfg_reps(cfg_reps),
        .load_start(load_start), .trigger(trigger), .stop(stop),
        .we(we), .waddr(waddr), .data_in(data_in),
        .re(re), .arb_rst_n(arb_rst_n), .loaded(loaded), .playing(playing),
        .err_short(err_short)
    );

    always #5 wclk = ~wclk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int len;        // cfg_len
        int last_idx;   // word carrying s_tlast, -1 = none
        bit rnd_data;
        bit rnd_valid;
        int reps;       // cfg_reps for the playback after the load
        int exp_writes;
        bit exp_err;
        int exp_re;     // total re-high cycles over the playback
        int exp_busy;   // total playing cycles over the playback
    } vec_t;

    vec_t        vecs[9];
    logic [31:0] words[$];
    logic [13:0] exp_s[$];
    bit          exp_err_m;

    // {re, arb_rst_n, playing, loaded} per playback phase
    localparam logic [3:0] PH_PREP = 4'b0011;
    localparam logic [3:0] PH_PLAY = 4'b1111;
    localparam logic [3:0] PH_GAP  = 4'b0011;
    localparam logic [3:0] PH_DONE = 4'b0101;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic build_words(input int n, input bit rnd);
        words.delete();
        for (int i = 0; i < n; i++)
            words.push_back(rnd ? $urandom : {16'(2 * i + 2), 16'(2 * i + 1)});
    endtask

    // Reference: the sample list the memory should hold after the transfer.
    task automatic model_load(input int len, input int last_idx);
        logic [13:0] pool[$];
        logic [31:0] w;
        int nw, lim;
        exp_s.delete();
        nw  = (last_idx < 0) ? words.size() : last_idx + 1;
        lim = (len > 65536) ? 65536 : len;
        for (int i = 0; i < nw; i++) begin
            w = words[i];
            pool.push_back(w[13:0]);
            pool.push_back(w[29:16]);
        end
        if (lim <= pool.size()) begin
            exp_err_m = 1'b0;
            for (int k = 0; k < lim; k++) exp_s.push_back(pool[k]);
        end else begin
            exp_err_m = (last_idx >= 0);
            for (int k = 0; k < pool.size(); k++) exp_s.push_back(pool[k]);
        end
    endtask

    task automatic do_load(input int len, input int last_idx, input bit rnd_valid,
                           input int exp_n, input bit exp_err);
        logic [15:0] ga[$];
        logic [13:0] gd[$];
        bit          tr[$];
        int          wi, cyc;
        bit          v;
        cfg_len    = 17'(len);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        wi  = 0;
        cyc = 0;
        while (loaded !== 1'b1 && cyc < 2000) begin
            v        = (wi < words.size()) && (!rnd_valid || $urandom_range(0, 3) != 0);
            s_tvalid = v;
            s_tdata  = v ? words[wi] : $urandom;
            s_tlast  = v && (wi == last_idx);
            tr.push_back(s_tready);
            if (v && s_tready) wi++;
            step();
            cyc++;
            if (we) begin
                ga.push_back(waddr);
                gd.push_back(data_in);
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("load_done", loaded, 1);
        check("write_count", ga.size(), exp_n);
        check("write_count_model", ga.size(), exp_s.size());
        for (int k = 0; k < ga.size() && k < exp_s.size(); k++) begin
            check($sformatf("waddr[%0d]", k), ga[k], k);
            check($sformatf("data_in[%0d]", k), gd[k], exp_s[k]);
        end
        check("err_short", err_short, exp_err);
        check("err_short_model", err_short, exp_err_m);
        check("idle_after_load", {re, playing}, 2'b00);
        if (!rnd_valid) begin
            check("load_cycles", cyc, exp_n);
            for (int i = 0; i < tr.size(); i++)
                check($sformatf("tready[%0d]", i), tr[i], (i % 2 == 0));
        end
        $display("load len=%0d last=%0d writes=%0d err_short=%0b cycles=%0d",
                 len, last_idx, ga.size(), err_short, cyc);
    endtask

    // Reference playback trace: PREP, then len reads per repetition with a
    // one-cycle gap between repetitions, cut short by stop if requested.
    task automatic do_play(input logic [15:0] reps, input int len, input int stop_at,
                           input bit stop_with_trig, input int exp_re, input int exp_busy);
        logic [3:0] seq[$];
        logic [3:0] obs;
        int  r, re_cnt, busy;
        bit  done;
        seq.push_back(PH_PREP);
        r    = 0;
        done = 1'b0;
        while (!done && (stop_at == 0 || seq.size() < stop_at) && seq.size() < 50000) begin
            for (int j = 0; j < len; j++) seq.push_back(PH_PLAY);
            r++;
            if (reps != 0 && r == reps) done = 1'b1;
            else seq.push_back(PH_GAP);
        end
        if (stop_at > 0)
            while (seq.size() > stop_at) void'(seq.pop_back());
        seq.push_back(PH_DONE);

        cfg_reps = reps;
        trigger  = 1'b1;
        stop     = stop_with_trig;
        step();
        trigger  = 1'b0;
        stop     = 1'b0;
        re_cnt   = 0;
        busy     = 0;
        for (int i = 0; i < seq.size(); i++) begin
            obs = {re, arb_rst_n, playing, loaded};
            check($sformatf("play_seq[%0d]", i), obs, seq[i]);
            if (re) re_cnt++;
            if (playing) busy++;
            if (i < seq.size() - 1) begin
                stop = (i == stop_at - 1);
                step();
                stop = 1'b0;
            end
        end
        check("re_cycles", re_cnt, exp_re);
        check("busy_cycles", busy, exp_busy);
        $display("play reps=%0d len=%0d stop_at=%0d re_cycles=%0d busy=%0d",
                 reps, len, stop_at, re_cnt, busy);
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        //            len last rndD rndV reps wr err re  busy
        vecs[0] = '{6,  -1, 0, 0, 1, 6, 0, 6,  7};
        vecs[1] = '{5,  -1, 0, 0, 2, 5, 0, 10, 12};
        vecs[2] = '{8,   1, 0, 0, 1, 4, 1, 4,  5};
        vecs[3] = '{4,  -1, 0, 0, 3, 4, 0, 12, 15};
        vecs[4] = '{1,  -1, 1, 1, 2, 1, 0, 2,  4};
        vecs[5] = '{7,   3, 1, 1, 1, 7, 0, 7,  8};
        vecs[6] = '{9,   2, 1, 0, 1, 6, 1, 6,  7};
        vecs[7] = '{6,   2, 1, 1, 1, 6, 0, 6,  7};
        vecs[8] = '{33, -1, 1, 1, 2, 33, 0, 66, 68};

        rst = 1'b1;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        cfg_len = '0; cfg_reps = '0;
        load_start = 1'b0; trigger = 1'b0; stop = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        check("rst_s_tready", s_tready, 0);
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_data_in", data_in, 0);
        check("rst_re", re, 0);
        check("rst_arb_rst_n", arb_rst_n, 0);
        check("rst_loaded", loaded, 0);
        check("rst_playing", playing, 0);
        check("rst_err_short", err_short, 0);
        rst = 1'b0;
        step();
        check("arb_rst_n_after_release", arb_rst_n, 1);
        check("idle_loaded", loaded, 0);
        check("idle_tready", s_tready, 0);

        for (int v = 0; v < 9; v++) begin
            int nw;
            nw = (vecs[v].last_idx < 0) ? (vecs[v].len + 1) / 2 : vecs[v].last_idx + 1;
            build_words(nw, vecs[v].rnd_data);
            model_load(vecs[v].len, vecs[v].last_idx);
            do_load(vecs[v].len, vecs[v].last_idx, vecs[v].rnd_valid,
                    vecs[v].exp_writes, vecs[v].exp_err);
            do_play(16'(vecs[v].reps), vecs[v].exp_writes, 0, 1'b0,
                    vecs[v].exp_re, vecs[v].exp_busy);
        end

        // Infinite repeats aborted by stop, then a fresh trigger restarts.
        do_play(16'd0, 33, 10, 1'b0, 9, 10);
        do_play(16'd1, 33, 0, 1'b0, 33, 34);
        // trigger and stop together in LOADED: trigger wins.
        do_play(16'd1, 33, 0, 1'b1, 33, 34);

        // stop while merely loaded does nothing.
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_in_loaded", {re, arb_rst_n, playing, loaded}, PH_DONE);
        $display("stop in LOADED ignored");

        // Reset in the middle of a load.
        build_words(4, 1'b0);
        cfg_len    = 17'd8;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        s_tvalid   = 1'b1;
        s_tdata    = words[0];
        step();
        s_tvalid   = 1'b0;
        check("pre_reset_we", we, 1);
        check("pre_reset_tready", s_tready, 0);
        #2 rst = 1'b1;
        #1;
        check("midload_rst_we", we, 0);
        check("midload_rst_tready", s_tready, 0);
        check("midload_rst_re", re, 0);
        check("midload_rst_loaded", loaded, 0);
        check("midload_rst_arb", arb_rst_n, 0);
        #1 rst = 1'b0;
        step();
        check("arb_after_midload_rst", arb_rst_n, 1);
        cfg_reps = 16'd1;
        trigger  = 1'b1;
        step();
        trigger  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("trig_after_rst_ignored", {re, playing, loaded}, 3'b000);
            step();
        end
        cfg_len    = '0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("zero_len_ignored", {s_tready, loaded}, 2'b00);
            step();
        end
        $display("reset during load and zero-length load_start handled");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
